vram_arbiter: RTL and testbench

Arbiter sharing one single-port video RAM between the core's load/store path and the HDMI scanout line-fill logic. Display line fetches are issued as fixed-length read bursts with priority; CPU accesses are single-beat and are guaranteed one slot after every display burst so neither side starves. Sits between `veryl_Core`'s VRAM window, the scanout line buffer and the VRAM block RAM, entirely in the core clock domain.

---
 rtl/vram_arbiter.sv | 129 ++++++++++++
 tb/tb_vram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: one single-port VRAM shared by CPU single beats and display read bursts.
// Revision 1.0
`default_nettype none

module vram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cpu_valid,
  input  logic                i_cpu_we,
  input  logic [ADDR_W-1:0]   i_cpu_addr,
  input  logic [DATA_W-1:0]   i_cpu_wdata,
  input  logic [DATA_W/8-1:0] i_cpu_wstrb,
  output logic                o_cpu_ready,
  output logic                o_cpu_rvalid,
  output logic [DATA_W-1:0]   o_cpu_rdata,
  input  logic                i_disp_req,
  input  logic [ADDR_W-1:0]   i_disp_addr,
  output logic                o_disp_rvalid,
  output logic [DATA_W-1:0]   o_disp_rdata,
  output logic                o_disp_done,
  output logic                o_disp_err,
  output logic                o_mem_en,
  output logic [DATA_W/8-1:0] o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int                CNT_W       = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_DISP = 1'b1
  } state_t;

  state_t              state_q;
  logic                disp_pend_q;
  logic                cpu_owed_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cpu_rvalid_q;
  logic                disp_rvalid_q;
  logic                disp_done_q;
  logic                disp_err_q;

  logic w_idle;
  logic w_disp_rd;
  logic w_last_beat;
  logic w_cpu_acc;
  logic w_cpu_wr;
  logic w_disp_start;
  logic w_disp_take;

  // No access is issued in a cycle where reset is being sampled.
  assign w_idle       = (state_q == S_IDLE) && !i_rst;
  assign w_disp_rd    = (state_q == S_DISP) && !i_rst;
  assign w_last_beat  = w_disp_rd && (cnt_q == C_LAST_BEAT);
  assign w_cpu_acc    = w_idle && i_cpu_valid && (cpu_owed_q || !disp_pend_q);
  assign w_cpu_wr     = w_cpu_acc && i_cpu_we;
  assign w_disp_start = w_idle && disp_pend_q && !(cpu_owed_q && i_cpu_valid);
  assign w_disp_take  = i_disp_req && (state_q == S_IDLE) && !disp_pend_q;

  assign o_cpu_ready  = w_cpu_acc;
  assign o_mem_en     = w_cpu_acc || w_disp_rd;
  assign o_mem_we     = w_cpu_wr ? i_cpu_wstrb : '0;
  assign o_mem_wdata  = w_cpu_wr ? i_cpu_wdata : '0;
  assign o_mem_addr   = w_disp_rd ? (base_q + ADDR_W'(cnt_q)) :
                        w_cpu_acc ? i_cpu_addr : '0;

  assign o_cpu_rvalid  = cpu_rvalid_q;
  assign o_cpu_rdata   = cpu_rvalid_q ? i_mem_rdata : '0;
  assign o_disp_rvalid = disp_rvalid_q;
  assign o_disp_rdata  = disp_rvalid_q ? i_mem_rdata : '0;
  assign o_disp_done   = disp_done_q;
  assign o_disp_err    = disp_err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      disp_pend_q   <= 1'b0;
      cpu_owed_q    <= 1'b0;
      base_q        <= '0;
      cnt_q         <= '0;
      cpu_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_done_q   <= 1'b0;
      disp_err_q    <= 1'b0;
    end else begin
      if (w_disp_start) begin
        state_q <= S_DISP;
      end else if (w_last_beat) begin
        state_q <= S_IDLE;
      end

      if (w_disp_start) begin
        cnt_q <= '0;
      end else if (w_disp_rd) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (w_disp_take) begin
        disp_pend_q <= 1'b1;
        base_q      <= i_disp_addr;
      end else if (w_disp_start) begin
        disp_pend_q <= 1'b0;
      end

      // The owed slot lives for exactly one idle cycle: used or forfeited.
      if (w_last_beat) begin
        cpu_owed_q <= 1'b1;
      end else if (w_idle) begin
        cpu_owed_q <= 1'b0;
      end

      cpu_rvalid_q  <= w_cpu_acc && !i_cpu_we;
      disp_rvalid_q <= w_disp_rd;
      disp_done_q   <= w_last_beat;
      disp_err_q    <= i_disp_req && !w_disp_take;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed timeline plus random traffic checked against a cycle-level reference model.
// Revision 1.0
`default_nettype none

module tb_vram_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int STRB_W    = DATA_W / 8;

  logic                clk = 1'b0;
  logic                i_rst;
  logic                i_cpu_valid;
  logic                i_cpu_we;
  logic [ADDR_W-1:0]   i_cpu_addr;
  logic [DATA_W-1:0]   i_cpu_wdata;
  logic [STRB_W-1:0]   i_cpu_wstrb;
  logic                o_cpu_ready;
  logic                o_cpu_rvalid;
  logic [DATA_W-1:0]   o_cpu_rdata;
  logic                i_disp_req;
  logic [ADDR_W-1:0]   i_disp_addr;
  logic                o_disp_rvalid;
  logic [DATA_W-1:0]   o_disp_rdata;
  logic                o_disp_done;
  logic                o_disp_err;
  logic                o_mem_en;
  logic [STRB_W-1:0]   o_mem_we;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic [DATA_W-1:0]   o_mem_wdata;
  logic [DATA_W-1:0]   i_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cpu_valid(i_cpu_valid), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .i_cpu_wstrb(i_cpu_wstrb),
    .o_cpu_ready(o_cpu_ready), .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_rvalid(o_disp_rvalid), .o_disp_rdata(o_disp_rdata),
    .o_disp_done(o_disp_done), .o_disp_err(o_disp_err),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  function automatic logic [DATA_W-1:0] initval(input int a);
    return (DATA_W'(a) * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Block RAM stand-in: data one cycle after a read strobe, junk otherwise.
  logic [DATA_W-1:0] ram [0:65535];
  logic [DATA_W-1:0] rd_q;
  assign i_mem_rdata = rd_q;

  initial begin : ram_model
    for (int a = 0; a < 65536; a++) ram[a] = initval(a);
    rd_q = '0;
    forever begin
      @(posedge clk);
      if (o_mem_en === 1'b1 && o_mem_we == '0) begin
        rd_q = ram[o_mem_addr];
      end else begin
        if (o_mem_en === 1'b1) begin
          for (int b = 0; b < STRB_W; b++)
            if (o_mem_we[b]) ram[o_mem_addr][8*b +: 8] = o_mem_wdata[8*b +: 8];
        end
        rd_q = $urandom;
      end
    end
  end

  // Reference model: arbitration rules applied once per cycle to abstract state.
  logic [DATA_W-1:0] ref_mem [0:65535];

  initial begin : model
    bit                 armed, m_pend, m_active, m_owed, busy, pend0, serve;
    logic [ADDR_W-1:0]  m_base, a;
    int                 m_issued;
    logic               e_ready, e_en;
    logic [STRB_W-1:0]  e_we;
    logic [ADDR_W-1:0]  e_addr;
    logic [DATA_W-1:0]  e_wd;
    logic               c_crv, c_drv, c_done, c_err, n_crv, n_drv, n_done, n_err;
    logic [DATA_W-1:0]  c_crd, c_drd, n_crd, n_drd;

    for (int i = 0; i < 65536; i++) ref_mem[i] = initval(i);
    armed = 0;
    forever begin
      @(negedge clk);
      if (!armed) begin
        if (i_rst === 1'b1) begin
          armed = 1; m_pend = 0; m_active = 0; m_owed = 0; m_base = '0; m_issued = 0;
          c_crv = 0; c_drv = 0; c_done = 0; c_err = 0; c_crd = '0; c_drd = '0;
        end
      end else begin
        e_ready = 0; e_en = 0; e_we = '0; e_addr = '0; e_wd = '0;
        n_crv = 0; n_drv = 0; n_done = 0; n_err = 0; n_crd = '0; n_drd = '0;
        if (i_rst) begin
          m_pend = 0; m_active = 0; m_owed = 0; m_issued = 0;
        end else begin
          busy = m_active; pend0 = m_pend; serve = 0;
          if (m_active) begin
            a = m_base + ADDR_W'(m_issued);
            e_en = 1; e_addr = a; n_drv = 1; n_drd = ref_mem[a];
            m_issued++;
            if (m_issued == BURST_LEN) begin
              m_active = 0; m_owed = 1; n_done = 1;
            end
          end else begin
            if (m_owed && i_cpu_valid) serve = 1;
            else if (m_pend) begin m_active = 1; m_issued = 0; m_pend = 0; end
            else if (i_cpu_valid) serve = 1;
            m_owed = 0;
          end
          if (serve) begin
            e_ready = 1; e_en = 1; e_addr = i_cpu_addr;
            if (i_cpu_we) begin
              e_we = i_cpu_wstrb; e_wd = i_cpu_wdata;
              for (int b = 0; b < STRB_W; b++)
                if (i_cpu_wstrb[b]) ref_mem[i_cpu_addr][8*b +: 8] = i_cpu_wdata[8*b +: 8];
            end else begin
              n_crv = 1; n_crd = ref_mem[i_cpu_addr];
            end
          end
          if (i_disp_req) begin
            if (!busy && !pend0) begin m_pend = 1; m_base = i_disp_addr; end
            else n_err = 1;
          end
        end
        chk("m_cpu_ready",   64'(o_cpu_ready),   64'(e_ready));
        chk("m_mem_en",      64'(o_mem_en),      64'(e_en));
        chk("m_mem_we",      64'(o_mem_we),      64'(e_we));
        chk("m_mem_addr",    64'(o_mem_addr),    64'(e_addr));
        chk("m_mem_wdata",   64'(o_mem_wdata),   64'(e_wd));
        chk("m_cpu_rvalid",  64'(o_cpu_rvalid),  64'(c_crv));
        chk("m_cpu_rdata",   64'(o_cpu_rdata),   64'(c_crd));
        chk("m_disp_rvalid", 64'(o_disp_rvalid), 64'(c_drv));
        chk("m_disp_rdata",  64'(o_disp_rdata),  64'(c_drd));
        chk("m_disp_done",   64'(o_disp_done),   64'(c_done));
        chk("m_disp_err",    64'(o_disp_err),    64'(c_err));
        c_crv = n_crv; c_crd = n_crd; c_drv = n_drv; c_drd = n_drd;
        c_done = n_done; c_err = n_err;
      end
    end
  end

  initial begin : stim
    bit acc;
    i_rst = 1; i_cpu_valid = 0; i_cpu_we = 0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_cpu_wstrb = '0; i_disp_req = 0; i_disp_addr = '0;
    cycle(); cycle();
    i_rst = 0;

    for (int k = 0; k < 10; k++) begin
      cycle();
      @(negedge clk);
      chk("idle_mem_en", 64'(o_mem_en), 64'd0);
      chk("idle_outs", 64'({o_cpu_ready, o_cpu_rvalid, o_disp_rvalid, o_disp_done, o_disp_err}), 64'd0);
    end

    cycle();
    i_cpu_valid = 1; i_cpu_we = 1; i_cpu_addr = 16'h0010;
    i_cpu_wdata = 32'hDEADBEEF; i_cpu_wstrb = 4'hF;
    @(negedge clk);
    chk("wr_ready", 64'(o_cpu_ready), 64'd1);
    chk("wr_mem_we", 64'(o_mem_we), 64'hF);
    chk("wr_mem_wdata", 64'(o_mem_wdata), 64'hDEADBEEF);
    cycle();
    i_cpu_we = 0;
    @(negedge clk);
    chk("rd_ready", 64'(o_cpu_ready), 64'd1);
    cycle();
    i_cpu_valid = 0;
    @(negedge clk);
    chk("rd_rvalid", 64'(o_cpu_rvalid), 64'd1);
    chk("rd_rdata", 64'(o_cpu_rdata), 64'hDEADBEEF);

    // Burst at 0x0100, owed CPU slot, wrapping burst at 0xFFFC, dropped request.
    for (int k = 0; k < 27; k++) begin
      cycle();
      i_disp_req  = (k == 0) || (k == 10) || (k == 14);
      i_disp_addr = (k == 0) ? 16'h0100 : (k == 10) ? 16'hFFFC : 16'h1234;
      if (k == 3) begin i_cpu_valid = 1; i_cpu_we = 0; i_cpu_addr = 16'h0010; end
      if (k == 11) i_cpu_valid = 0;
      @(negedge clk);
      case (k)
        1:  chk("b1_no_read_yet", 64'(o_mem_en), 64'd0);
        2:  chk("b1_first_addr", 64'(o_mem_addr), 64'h0100);
        3:  chk("b1_first_beat", 64'(o_disp_rvalid), 64'd1);
        9:  begin
              chk("b1_last_addr", 64'(o_mem_addr), 64'h0107);
              chk("b1_cpu_waits", 64'(o_cpu_ready), 64'd0);
            end
        10: begin
              chk("b1_done", 64'(o_disp_done), 64'd1);
              chk("owed_ready", 64'(o_cpu_ready), 64'd1);
              chk("owed_addr", 64'(o_mem_addr), 64'h0010);
            end
        11: begin
              chk("owed_rdata", 64'(o_cpu_rdata), 64'hDEADBEEF);
              chk("b2_start_gap", 64'(o_mem_en), 64'd0);
            end
        12: chk("b2_first_addr", 64'(o_mem_addr), 64'hFFFC);
        15: chk("b2_err_pulse", 64'(o_disp_err), 64'd1);
        16: begin
              chk("b2_wrap_addr", 64'(o_mem_addr), 64'h0000);
              chk("b2_err_single", 64'(o_disp_err), 64'd0);
            end
        19: chk("b2_last_addr", 64'(o_mem_addr), 64'h0003);
        20: chk("b2_done", 64'(o_disp_done), 64'd1);
        default: if (k >= 21) chk("no_extra_burst", 64'(o_mem_en), 64'd0);
      endcase
    end

    // Reset in the middle of a burst.
    for (int k = 0; k < 15; k++) begin
      cycle();
      i_disp_req  = (k == 0);
      i_disp_addr = 16'h0200;
      i_rst       = (k == 5);
      @(negedge clk);
      if (k == 4) chk("b3_beat_before_rst", 64'(o_disp_rvalid), 64'd1);
      if (k >= 6) begin
        chk("b3_no_beats_after_rst", 64'(o_disp_rvalid), 64'd0);
        chk("b3_no_done_after_rst", 64'(o_disp_done), 64'd0);
        chk("b3_no_access_after_rst", 64'(o_mem_en), 64'd0);
      end
    end

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = i_cpu_valid && o_cpu_ready;
      cycle();
      if (!i_cpu_valid || acc) begin
        if ($urandom_range(0, 99) < 45) begin
          i_cpu_valid = 1;
          i_cpu_we    = 1'($urandom_range(0, 1));
          i_cpu_addr  = 16'($urandom_range(0, 63));
          i_cpu_wdata = $urandom;
          i_cpu_wstrb = 4'($urandom_range(1, 15));
        end else begin
          i_cpu_valid = 0;
        end
      end
      i_disp_req  = ($urandom_range(0, 99) < 8);
      i_disp_addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                                 : 16'($urandom);
      i_rst       = ($urandom_range(0, 499) == 0);
    end

    cycle();
    i_cpu_valid = 0; i_disp_req = 0; i_rst = 0;
    repeat (20) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
